// File: rtl/ryu_sprite_pkg.sv
// Shared constants, types and helpers for the Ryu jump sprite fetch stage.
package ryu_sprite_pkg;

    localparam int unsigned SPR_W      = 64;
    localparam int unsigned SPR_H      = 96;
    localparam int unsigned N_FRAMES   = 6;
    localparam int unsigned FRAME_HOLD = 4;
    localparam int unsigned ADDR_W     = 16;

    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

    typedef enum logic {IDLE, PLAY} anim_state_t;

    // Base ROM address of an animation frame; unrolls into a constant mux.
    function automatic logic [31:0] frame_base(input logic [2:0] idx,
                                               input int unsigned frame_size);
        logic [31:0] base;
        base = '0;
        for (int i = 0; i < 8; i++) begin
            if (idx == 3'(i)) begin
                base = 32'(i) * frame_size;
            end
        end
        return base;
    endfunction

endpackage

// File: rtl/ryu_anim_ctrl.sv
// Jump animation sequencer: steps frame_idx every FRAME_HOLD video frames while playing.
module ryu_anim_ctrl
    import ryu_sprite_pkg::*;
#(
    parameter int unsigned N_FRAMES   = ryu_sprite_pkg::N_FRAMES,
    parameter int unsigned FRAME_HOLD = ryu_sprite_pkg::FRAME_HOLD
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_start,
    input  logic       jump_trig,
    output logic [2:0] frame_idx,
    output logic       anim_busy
);

    localparam int unsigned HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    anim_state_t       state_q, state_d;
    logic [2:0]        frame_idx_q, frame_idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            frame_idx_q <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            frame_idx_q <= frame_idx_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_idx_d = frame_idx_q;
        hold_d      = hold_q;
        unique case (state_q)
            IDLE: begin
                frame_idx_d = '0;
                hold_d      = '0;
                if (jump_trig) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // Only frame_start moves the animation, so frames never tear mid-scan.
                if (frame_start) begin
                    if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
                        hold_d = '0;
                        if (frame_idx_q == 3'(N_FRAMES - 1)) begin
                            state_d     = IDLE;
                            frame_idx_d = '0;
                        end else begin
                            frame_idx_d = frame_idx_q + 3'd1;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
        endcase
    end

    assign frame_idx = frame_idx_q;
    assign anim_busy = (state_q == PLAY);

endmodule

// File: rtl/ryu_jump_sprite_fetch.sv
// Sprite box test, ROM address pipeline and palette-index gating for the Ryu jump sprite.
module ryu_jump_sprite_fetch
    import ryu_sprite_pkg::*;
#(
    parameter int unsigned SPR_W      = ryu_sprite_pkg::SPR_W,
    parameter int unsigned SPR_H      = ryu_sprite_pkg::SPR_H,
    parameter int unsigned N_FRAMES   = ryu_sprite_pkg::N_FRAMES,
    parameter int unsigned FRAME_HOLD = ryu_sprite_pkg::FRAME_HOLD,
    parameter int unsigned ADDR_W     = ryu_sprite_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic              jump_trig,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        SpriteX,
    input  logic [9:0]        SpriteY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        pix_index,
    output logic              pix_valid,
    output logic              anim_busy,
    output logic [2:0]        frame_idx
);

    localparam int unsigned SPR_SHIFT  = $clog2(SPR_W);
    localparam int unsigned FRAME_SIZE = SPR_W * SPR_H;

    logic [10:0]       rel_x, rel_y;
    logic              inbox;
    logic [ADDR_W-1:0] addr_next;
    logic              inbox_d1, inbox_d2;

    ryu_anim_ctrl #(
        .N_FRAMES   (N_FRAMES),
        .FRAME_HOLD (FRAME_HOLD)
    ) u_anim_ctrl (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .jump_trig   (jump_trig),
        .frame_idx   (frame_idx),
        .anim_busy   (anim_busy)
    );

    // 11-bit differences so a pixel left of / above the box shows up as negative.
    assign rel_x = {1'b0, DrawX} - {1'b0, SpriteX};
    assign rel_y = {1'b0, DrawY} - {1'b0, SpriteY};

    assign inbox = !rel_x[10] && (rel_x < 11'(SPR_W)) &&
                   !rel_y[10] && (rel_y < 11'(SPR_H));

    always_comb begin
        addr_next = '0;
        if (inbox) begin
            addr_next = ADDR_W'(frame_base(frame_idx, FRAME_SIZE))
                      + (ADDR_W'(rel_y) << SPR_SHIFT)
                      + ADDR_W'(rel_x);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            inbox_d1 <= 1'b0;
            inbox_d2 <= 1'b0;
        end else begin
            rom_addr <= addr_next;
            inbox_d1 <= inbox;
            inbox_d2 <= inbox_d1;
        end
    end

    // inbox_d2 lines up with rom_data, which lags rom_addr by one cycle.
    assign pix_index = inbox_d2 ? rom_data : 4'h0;
    assign pix_valid = inbox_d2 && (rom_data != TRANSPARENT_IDX);

endmodule

// File: tb/tb_ryu_jump_sprite_fetch.sv
// Directed self-checking bench for ryu_jump_sprite_fetch with a behavioural sprite ROM.
module tb_ryu_jump_sprite_fetch;

    logic        Clk;
    logic        Reset_n;
    logic        frame_start;
    logic        jump_trig;
    logic [9:0]  DrawX, DrawY, SpriteX, SpriteY;
    logic [15:0] rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  pix_index;
    logic        pix_valid;
    logic        anim_busy;
    logic [2:0]  frame_idx;

    int tests;
    int fails;

    ryu_jump_sprite_fetch dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .jump_trig   (jump_trig),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .SpriteX     (SpriteX),
        .SpriteY     (SpriteY),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pix_index   (pix_index),
        .pix_valid   (pix_valid),
        .anim_busy   (anim_busy),
        .frame_idx   (frame_idx)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [3:0] rom_val(input logic [15:0] a);
        return a[3:0] ^ a[9:6];
    endfunction

    always_ff @(posedge Clk) rom_data <= rom_val(rom_addr);

    // Returns -1 when the pixel lies outside the 64x96 box.
    function automatic int model_addr(input int dx, input int dy, input int sx, input int sy,
                                      input int fr);
        int rx, ry;
        rx = dx - sx;
        ry = dy - sy;
        if (rx < 0 || rx >= 64 || ry < 0 || ry >= 96) return -1;
        return fr * 6144 + ry * 64 + rx;
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_frame;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_trig;
        jump_trig = 1'b1;
        tick();
        jump_trig = 1'b0;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0;
        tick();
        tick();
        tests++;
        if (rom_addr !== 16'd0) begin
            fails++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr);
        end
        tests++;
        if (pix_valid !== 1'b0 || pix_index !== 4'd0) begin
            fails++; $display("FAIL reset_pix got valid=%0b idx=%0d want 0/0", pix_valid, pix_index);
        end
        tests++;
        if (anim_busy !== 1'b0 || frame_idx !== 3'd0) begin
            fails++; $display("FAIL reset_anim got busy=%0b frame=%0d want 0/0", anim_busy, frame_idx);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_addr;
        SpriteX = 10'd100; SpriteY = 10'd50;
        DrawX = 10'd103; DrawY = 10'd52;
        tick();
        tests++;
        if (rom_addr !== 16'd131) begin
            fails++; $display("FAIL addr_131 got %0d want 131", rom_addr);
        end
        tick();
        tests++;
        if (pix_index !== rom_val(16'd131) || pix_valid !== 1'b1) begin
            fails++; $display("FAIL addr_131_pix got idx=%0d valid=%0b want %0d/1",
                              pix_index, pix_valid, rom_val(16'd131));
        end
        DrawX = 10'd163; DrawY = 10'd145;
        tick();
        tests++;
        if (rom_addr !== 16'd6143) begin
            fails++; $display("FAIL addr_corner got %0d want 6143", rom_addr);
        end
    endtask

    task automatic test_outside;
        logic [9:0] xs [4];
        logic [9:0] ys [4];
        xs = '{10'd99, 10'd164, 10'd120, 10'd120};
        ys = '{10'd52, 10'd52, 10'd49, 10'd146};
        for (int i = 0; i < 4; i++) begin
            DrawX = xs[i]; DrawY = ys[i];
            tick();
            tests++;
            if (rom_addr !== 16'd0) begin
                fails++; $display("FAIL outside_addr_%0d got %0d want 0", i, rom_addr);
            end
            tick();
            tests++;
            if (pix_valid !== 1'b0 || pix_index !== 4'd0) begin
                fails++; $display("FAIL outside_pix_%0d got valid=%0b idx=%0d want 0/0",
                                  i, pix_valid, pix_index);
            end
        end
        // Box hanging off the right edge: a pixel on the left must not wrap into it.
        SpriteX = 10'd600; DrawX = 10'd5; DrawY = 10'd60;
        tick();
        tests++;
        if (rom_addr !== 16'd0) begin
            fails++; $display("FAIL clip_wrap got %0d want 0", rom_addr);
        end
        DrawX = 10'd639;
        tick();
        tests++;
        if (rom_addr !== 16'd679) begin
            fails++; $display("FAIL clip_edge got %0d want 679", rom_addr);
        end
        SpriteX = 10'd100;
    endtask

    task automatic test_transparent;
        DrawX = 10'd100; DrawY = 10'd50;
        tick();
        tick();
        tests++;
        if (pix_valid !== 1'b0 || pix_index !== 4'd0) begin
            fails++; $display("FAIL transparent got valid=%0b idx=%0d want 0/0", pix_valid, pix_index);
        end
        DrawX = 10'd107;
        tick();
        tick();
        tests++;
        if (pix_valid !== 1'b1 || pix_index !== 4'd7) begin
            fails++; $display("FAIL opaque7 got valid=%0b idx=%0d want 1/7", pix_valid, pix_index);
        end
    endtask

    task automatic test_anim;
        int exp_idx;
        logic exp_busy;
        pulse_frame();
        tests++;
        if (anim_busy !== 1'b0 || frame_idx !== 3'd0) begin
            fails++; $display("FAIL idle_ignores_frame got busy=%0b frame=%0d want 0/0",
                              anim_busy, frame_idx);
        end
        pulse_trig();
        tests++;
        if (anim_busy !== 1'b1 || frame_idx !== 3'd0) begin
            fails++; $display("FAIL trig_start got busy=%0b frame=%0d want 1/0", anim_busy, frame_idx);
        end
        for (int n = 1; n <= 24; n++) begin
            jump_trig = (n >= 5 && n <= 8) || (n == 24);
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            jump_trig = (n >= 5 && n < 8);
            exp_idx = (n == 24) ? 0 : n / 4;
            exp_busy = (n != 24);
            tests++;
            if (frame_idx !== 3'(exp_idx) || anim_busy !== exp_busy) begin
                fails++; $display("FAIL anim_pulse_%0d got frame=%0d busy=%0b want %0d/%0b",
                                  n, frame_idx, anim_busy, exp_idx, exp_busy);
            end
            tick();
        end
        jump_trig = 1'b0;
        tick();
        tests++;
        if (anim_busy !== 1'b0 || frame_idx !== 3'd0) begin
            fails++; $display("FAIL trig_lost got busy=%0b frame=%0d want 0/0", anim_busy, frame_idx);
        end
    endtask

    task automatic test_frame2_sweep;
        int ea, pa;
        logic pin;
        logic [3:0] ei;
        pulse_trig();
        for (int n = 0; n < 8; n++) pulse_frame();
        tests++;
        if (frame_idx !== 3'd2) begin
            fails++; $display("FAIL frame2_reach got %0d want 2", frame_idx);
        end
        SpriteX = 10'd100; SpriteY = 10'd50;
        DrawX = 10'd100; DrawY = 10'd50;
        tick();
        tests++;
        if (rom_addr !== 16'd12288) begin
            fails++; $display("FAIL frame2_base got %0d want 12288", rom_addr);
        end
        DrawX = 10'd0; DrawY = 10'd0;
        tick();
        tick();
        pa = 0; pin = 1'b0;
        for (int y = 40; y <= 150; y += 5) begin
            for (int x = 90; x <= 175; x++) begin
                DrawX = 10'(x); DrawY = 10'(y);
                ea = model_addr(x, y, 100, 50, 2);
                tick();
                tests++;
                if (rom_addr !== 16'((ea < 0) ? 0 : ea)) begin
                    fails++; $display("FAIL sweep_addr x=%0d y=%0d got %0d want %0d",
                                      x, y, rom_addr, (ea < 0) ? 0 : ea);
                end
                ei = pin ? rom_val(16'(pa)) : 4'd0;
                tests++;
                if (pix_index !== ei || pix_valid !== (pin && ei != 4'd0)) begin
                    fails++; $display("FAIL sweep_pix x=%0d y=%0d got idx=%0d valid=%0b want %0d/%0b",
                                      x, y, pix_index, pix_valid, ei, pin && ei != 4'd0);
                end
                pin = (ea >= 0);
                pa = (ea < 0) ? 0 : ea;
            end
        end
    endtask

    task automatic test_reset_mid_play;
        for (int n = 0; n < 4; n++) pulse_frame();
        DrawX = 10'd101; DrawY = 10'd50;
        tick();
        tick();
        tests++;
        if (frame_idx !== 3'd3 || pix_valid !== 1'b1 || rom_addr !== 16'd18433) begin
            fails++; $display("FAIL pre_reset got frame=%0d valid=%0b addr=%0d want 3/1/18433",
                              frame_idx, pix_valid, rom_addr);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        tests++;
        if (frame_idx !== 3'd0 || anim_busy !== 1'b0 || pix_valid !== 1'b0 || rom_addr !== 16'd0) begin
            fails++; $display("FAIL async_reset got frame=%0d busy=%0b valid=%0b addr=%0d want 0/0/0/0",
                              frame_idx, anim_busy, pix_valid, rom_addr);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
        tests++;
        if (anim_busy !== 1'b0 || frame_idx !== 3'd0) begin
            fails++; $display("FAIL post_reset got busy=%0b frame=%0d want 0/0", anim_busy, frame_idx);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        frame_start = 1'b0;
        jump_trig = 1'b0;
        DrawX = '0; DrawY = '0; SpriteX = 10'd100; SpriteY = 10'd50;
        test_reset();
        test_addr();
        test_outside();
        test_transparent();
        test_anim();
        test_frame2_sweep();
        test_reset_mid_play();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
